// File: rtl/rx_eyeq_pkg.sv
// ============================================================================
// Module      : rx_eyeq_pkg
// Description : Shared types for the RX eye-quality handshake controller:
//               PHY eye-Q mode, powerdown encoding and controller FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_eyeq_pkg;

  localparam int EYEQMODE_W  = 2;
  localparam int POWERDOWN_W = 2;

  typedef enum logic [EYEQMODE_W-1:0] {
    EYEQ_MODE_OFF   = 2'd0,
    STARTUP_NRZ_DDR = 2'd1,
    STARTUP_NRZ_SDR = 2'd2,
    PERIODIC_NRZ    = 2'd3
  } eyeqmode_t;

  typedef enum logic [POWERDOWN_W-1:0] {
    POWERDOWN_NORMAL = 2'd0,
    POWERDOWN_COMA   = 2'd1,
    POWERDOWN_P1     = 2'd2,
    POWERDOWN_P2     = 2'd3
  } powerdown_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRECHK  = 3'd1,
    ST_REQ     = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FINISH  = 3'd4
  } eyeq_state_t;

endpackage

`default_nettype wire

// File: rtl/rx_eyeq_ctrl_if.sv
// ============================================================================
// Module      : rx_eyeq_ctrl_if
// Description : Bundle of control-side and PHY-side signals of the eye-Q
//               controller. slave = controller view, master = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_eyeq_ctrl_if
  import rx_eyeq_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int METRIC_W  = 8,
  parameter int TIMEOUT_W = 16
) ();

  logic                          start_i;
  eyeqmode_t                     mode_i;
  logic [NUM_LANES-1:0]          lane_en_i;
  powerdown_t                    rxpdwn_i;
  logic [TIMEOUT_W-1:0]          timeout_i;
  logic [NUM_LANES-1:0]          rxeyeqdone_i;
  logic [NUM_LANES*METRIC_W-1:0] rxeyeq_i;

  logic [NUM_LANES-1:0]          rxeyeqreq_o;
  eyeqmode_t                     rxeyeqmode_o;
  logic [NUM_LANES*METRIC_W-1:0] metric_o;
  logic                          busy_o;
  logic                          complete_o;
  logic                          error_o;
  logic [NUM_LANES-1:0]          fail_mask_o;

  modport slave (
    input  start_i, mode_i, lane_en_i, rxpdwn_i, timeout_i, rxeyeqdone_i, rxeyeq_i,
    output rxeyeqreq_o, rxeyeqmode_o, metric_o, busy_o, complete_o, error_o, fail_mask_o
  );

  modport master (
    output start_i, mode_i, lane_en_i, rxpdwn_i, timeout_i, rxeyeqdone_i, rxeyeq_i,
    input  rxeyeqreq_o, rxeyeqmode_o, metric_o, busy_o, complete_o, error_o, fail_mask_o
  );

endinterface

`default_nettype wire

// File: rtl/rx_eyeq_lane.sv
// ============================================================================
// Module      : rx_eyeq_lane
// Description : Per-lane slice: request register, metric capture register and
//               detection of a done rising on a lane not taking part.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_eyeq_lane #(
  parameter int METRIC_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic                i_req_on,
  input  logic                i_capture,
  input  logic                i_track,
  input  logic                i_done,
  input  logic [METRIC_W-1:0] i_metric,
  output logic                o_req,
  output logic [METRIC_W-1:0] o_metric,
  output logic                o_stray
);

  logic                r_req;
  logic [METRIC_W-1:0] r_metric;
  logic                r_done_d;

  // Request may only rise while done is low; once up it holds until released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req    <= 1'b0;
      r_metric <= '0;
      r_done_d <= 1'b0;
    end else begin
      r_req    <= i_req_on & i_en & (r_req | ~i_done);
      r_done_d <= i_done;
      if (i_capture && i_en) begin
        r_metric <= i_metric;
      end
    end
  end

  assign o_req    = r_req;
  assign o_metric = r_metric;
  assign o_stray  = i_track & ~i_en & i_done & ~r_done_d;

endmodule

`default_nettype wire

// File: rtl/rx_eyeq_ctrl.sv
// ============================================================================
// Module      : rx_eyeq_ctrl
// Description : Runs one PHY eye-quality request/done handshake across the
//               enabled RX lanes and captures their eye metrics.
//               Optional macro RX_EYEQ_TIMEOUT_EN adds a per-phase timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_eyeq_ctrl
  import rx_eyeq_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int METRIC_W  = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rx_eyeq_ctrl_if.slave bus
);

  eyeq_state_t                   r_state;
  eyeq_state_t                   w_state_nxt;
  eyeqmode_t                     r_mode;
  logic [NUM_LANES-1:0]          r_mask;
  logic [NUM_LANES-1:0]          r_fail;
  logic [NUM_LANES-1:0]          w_fail_nxt;
  logic                          r_err_pulse;
  logic [NUM_LANES-1:0]          w_done_en;
  logic                          w_all_done;
  logic                          w_none_done;
  logic                          w_pd_normal;
  logic                          w_start_ok;
  logic                          w_pd_err;
  logic                          w_abort;
  logic                          w_capture;
  logic                          w_timeout;
  logic                          w_to_hit;
  logic [NUM_LANES-1:0]          w_to_mask;
  logic                          w_busy;
  logic                          w_req_on;
  logic [NUM_LANES-1:0]          w_req;
  logic [NUM_LANES-1:0]          w_stray;
  logic [NUM_LANES*METRIC_W-1:0] w_metric;

  assign w_done_en   = bus.rxeyeqdone_i & r_mask;
  assign w_all_done  = (w_done_en == r_mask);
  assign w_none_done = (w_done_en == '0);
  assign w_pd_normal = (bus.rxpdwn_i == POWERDOWN_NORMAL);
  assign w_busy      = (r_state != ST_IDLE);

`ifdef RX_EYEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 w_in_wait;

  assign w_in_wait = (r_state == ST_PRECHK) || (r_state == ST_REQ) || (r_state == ST_RELEASE);
  assign w_to_hit  = w_in_wait && (bus.timeout_i != '0) && (r_cnt == bus.timeout_i);

  // Lanes that have not yet met the wait condition of the current phase.
  always_comb begin
    w_to_mask = '0;
    case (r_state)
      ST_PRECHK:  w_to_mask = w_done_en;
      ST_REQ:     w_to_mask = r_mask & ~bus.rxeyeqdone_i;
      ST_RELEASE: w_to_mask = w_done_en;
      default:    w_to_mask = '0;
    endcase
  end

  // Phase cycle counter: restarts on every state change, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (w_in_wait && (r_cnt != {TIMEOUT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_to_hit         = 1'b0;
  assign w_to_mask        = '0;
  assign w_unused_timeout = ^bus.timeout_i;
`endif

  // Handshake sequencing; an expired phase timeout overrides a stalled state.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_pd_err    = 1'b0;
    w_abort     = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (!w_pd_normal) begin
            w_pd_err = 1'b1;
          end else begin
            w_start_ok  = 1'b1;
            w_state_nxt = (bus.lane_en_i == '0) ? ST_FINISH : ST_PRECHK;
          end
        end
      end
      ST_PRECHK: begin
        if (w_none_done) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (!w_pd_normal) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else if (w_all_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (w_none_done) w_state_nxt = ST_FINISH;
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_to_hit && (w_state_nxt == r_state)) begin
      w_timeout   = 1'b1;
      w_state_nxt = ST_IDLE;
    end
  end

  // Failing-lane record: cleared per handshake, loaded by immediate errors,
  // accumulated from stray dones; a powerdown abort blames every enabled lane.
  always_comb begin
    w_fail_nxt = r_fail | w_stray;
    if (w_start_ok)     w_fail_nxt = '0;
    else if (w_pd_err)  w_fail_nxt = bus.lane_en_i;
    else if (w_timeout) w_fail_nxt = w_to_mask;
    else if (w_abort)   w_fail_nxt = r_fail | r_mask | w_stray;
  end

  // State, latched request context and error bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= EYEQ_MODE_OFF;
      r_mask      <= '0;
      r_fail      <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fail      <= w_fail_nxt;
      r_err_pulse <= w_pd_err | w_timeout;
      if (w_start_ok) begin
        r_mode <= bus.mode_i;
        r_mask <= bus.lane_en_i;
      end else if ((r_state == ST_FINISH) || w_timeout) begin
        r_mode <= EYEQ_MODE_OFF;
        r_mask <= '0;
      end
    end
  end

  assign w_req_on = (r_state == ST_REQ) && (w_state_nxt == ST_REQ);

  generate
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      rx_eyeq_lane #(
        .METRIC_W (METRIC_W)
      ) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_mask[k]),
        .i_req_on  (w_req_on),
        .i_capture (w_capture),
        .i_track   (w_busy),
        .i_done    (bus.rxeyeqdone_i[k]),
        .i_metric  (bus.rxeyeq_i[k*METRIC_W +: METRIC_W]),
        .o_req     (w_req[k]),
        .o_metric  (w_metric[k*METRIC_W +: METRIC_W]),
        .o_stray   (w_stray[k])
      );
    end
  endgenerate

  assign bus.rxeyeqreq_o  = w_req;
  assign bus.rxeyeqmode_o = r_mode;
  assign bus.metric_o     = w_metric;
  assign bus.busy_o       = w_busy;
  assign bus.complete_o   = (r_state == ST_FINISH) && (r_fail == '0);
  assign bus.error_o      = r_err_pulse || ((r_state == ST_FINISH) && (r_fail != '0));
  assign bus.fail_mask_o  = r_fail;

endmodule

`default_nettype wire
